wishbone_rr_arbiter: RTL and testbench
======================================

# wishbone_rr_arbiter

Registered two-master Wishbone arbiter. It shares one slave bus (8-bit data, 16-bit address) between two masters. A grant is held for a master's whole `cyc` period, and ties are resolved round-robin so neither master starves. It sits between the two bus masters and the shared memory/peripheral interconnect. It replaces the combinational fixed-priority selection.

## Interface
Parameters:
- `DW`, 8: data width.
- `AW`, 16: address width.
- `TIMEOUT`, 15: watchdog limit, in cycles of `stb` without `ack`. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rst_n_i`, in, 1: asynchronous, active-low reset.
- `dat_o`, out, DW: data to the slave.
- `adr_o`, out, AW: address to the slave.
- `we_o`, out, 1: write enable to the slave.
- `stb_o`, out, 1: strobe to the slave.
- `cyc_o`, out, 1: cycle to the slave.
- `ack_i`, in, 1: acknowledge from the slave.
- `dat_o1`, `adr_o1`, `we_o1`, `stb_o1`, `cyc_o1`, in, DW/AW/1/1/1: master 1 request.
- `ack_i1`, out, 1: acknowledge to master 1.
- `dat_o2`, `adr_o2`, `we_o2`, `stb_o2`, `cyc_o2`, in, DW/AW/1/1/1: master 2 request.
- `ack_i2`, out, 1: acknowledge to master 2.
- `gnt_o`, out, 2: current grant, one-hot. `2'b01` = master 1, `2'b10` = master 2, `2'b00` = none.
- `tout_o`, out, 1: one-cycle pulse on watchdog abort. Tied to 0 when the feature is compiled out.

## Operation
- FSM states: `IDLE`, `GNT1`, `GNT2`, `ABORT`. `ABORT` exists only with the macro.
- `last` register records the most recently granted master.
- In `IDLE`:
  - Only `cyc_o1` high: go to `GNT1`.
  - Only `cyc_o2` high: go to `GNT2`.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in `IDLE`.
- On entering `GNTx`, `last` is set to x.
- In `GNTx`: stay while `cyc_ox` is high. When `cyc_ox` is low, go to `IDLE`. There is no direct `GNT1`↔`GNT2` hop.
- Bus outputs are combinational muxes selected by the registered state:
  - In `GNTx`, `dat_o`/`adr_o`/`we_o`/`stb_o`/`cyc_o` follow master x.
  - In `IDLE` and `ABORT`, all bus outputs are 0.
- `ack_ix = ack_i & (state == GNTx)`. The non-granted master always sees `ack` = 0.
- Request inputs of the non-granted master are ignored and never reach the slave.
- `gnt_o` decodes the state: `GNT1` → `01`, `GNT2` → `10`, otherwise `00`.

## Timing
- Reset (async assert, sync release): state `IDLE`, `last` = master 2 (master 1 wins the first tie), watchdog counter 0.
  - All outputs are 0: bus outputs, `ack_i1`, `ack_i2`, `gnt_o`, `tout_o`.
- Grant latency: `cyc_ox` rising in cycle n is sampled at the edge ending cycle n. `gnt_o` and the slave-side signals are valid in cycle n+1.
- Release: `cyc_ox` falling in cycle n leaves the arbiter in `IDLE` for cycle n+1. The earliest next grant is visible in cycle n+2. The one idle cycle between owners is mandatory.
- Slave-side path is combinational within a grant: master x changes `stb`/`adr` in cycle k, and they appear on the slave side in cycle k. `ack_i` reaches master x in the same cycle.
- Simultaneous requests in `IDLE` alternate grants on successive arbitrations.
- Reset asserted mid-transfer: grant is dropped immediately and all outputs go to 0 asynchronously.

## Configuration
- Macro `WB_ARB_TIMEOUT_EN` compiles in the watchdog.
- With the macro:
  - Counter clears in `IDLE`, on `ack_i`, and whenever `stb` of the granted master is low.
  - Counter increments each `GNTx` cycle with `stb` high and `ack_i` low.
  - When the counter reaches `TIMEOUT`, next state is `ABORT` and `tout_o` pulses high for that first `ABORT` cycle.
  - `ABORT` holds the bus deasserted and gives no acks. It exits to `IDLE` once `cyc_ox` of the aborted master is low.
- Without the macro: no counter, no `ABORT` state, `tout_o` = 0. A hung slave holds the grant indefinitely.

## Test plan
- Reset mid-grant: assert `rst_n_i` low during `GNT1` → all outputs 0 immediately. After release, a tie grants master 1 first.
- Single master: `cyc_o1` = `stb_o1` = 1, `adr_o1` = 16'h1234, `dat_o1` = 8'hA5, `we_o1` = 1.
  - Next cycle: `gnt_o` = 01 and the slave sees 16'h1234/8'hA5/`we` = 1.
  - `ack_i` pulse reaches `ack_i1` only. `ack_i2` stays 0.
- Tie after reset: both `cyc` rise in the same cycle → master 1 granted, master 2 ignored.
  - After master 1 drops `cyc`: one `IDLE` cycle, then master 2 is granted.
  - Next tie: master 1 is granted.
- Contention hold: master 2 requests while master 1 holds `cyc` for 6 cycles → `gnt_o` stays 01 all 6 cycles, and master 2's address never appears on `adr_o`.
- Watchdog (with `WB_ARB_TIMEOUT_EN`, `TIMEOUT` = 15): master 1 strobes and the slave never acks.
  - After 15 cycles: `tout_o` pulses once and `cyc_o`/`stb_o` go 0.
  - Arbiter returns to `IDLE` only after `cyc_o1` drops.
  - Without the macro, the grant holds past 100 cycles and `tout_o` stays 0.

Source files
------------

// File: rtl/wishbone_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_rr_arbiter
//
// Registered two-master Wishbone arbiter. One shared slave bus is handed to
// one master at a time. A grant lasts for the owner's whole cyc period, and
// simultaneous requests alternate round-robin so neither master starves.
// Exactly one idle cycle always separates two owners.
//
// Ports
//   clk_i, rst_n_i            : clock (rising edge), async active-low reset
//   dat_o/adr_o/we_o/stb_o/cyc_o, ack_i
//                             : shared slave bus (data, address, write enable,
//                               strobe, cycle) and slave acknowledge
//   dat_o1/adr_o1/we_o1/stb_o1/cyc_o1, ack_i1
//                             : master 1 request and its acknowledge
//   dat_o2/adr_o2/we_o2/stb_o2/cyc_o2, ack_i2
//                             : master 2 request and its acknowledge
//   gnt_o                     : one-hot grant (01 = master 1, 10 = master 2)
//   tout_o                    : one-cycle pulse on a watchdog abort
//
// Optional feature
//   WB_ARB_TIMEOUT_EN         : define to build in the watchdog. The granted
//                               master is aborted after TIMEOUT cycles of
//                               stb without ack. Without it, tout_o is 0 and
//                               a hung slave keeps the grant.
// ---------------------------------------------------------------------------
module wishbone_rr_arbiter #(
  parameter int DW      = 8,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  // shared slave bus
  output logic [DW-1:0] dat_o,
  output logic [AW-1:0] adr_o,
  output logic          we_o,
  output logic          stb_o,
  output logic          cyc_o,
  input  logic          ack_i,
  // master 1
  input  logic [DW-1:0] dat_o1,
  input  logic [AW-1:0] adr_o1,
  input  logic          we_o1,
  input  logic          stb_o1,
  input  logic          cyc_o1,
  output logic          ack_i1,
  // master 2
  input  logic [DW-1:0] dat_o2,
  input  logic [AW-1:0] adr_o2,
  input  logic          we_o2,
  input  logic          stb_o2,
  input  logic          cyc_o2,
  output logic          ack_i2,
  // status
  output logic [1:0]    gnt_o,
  output logic          tout_o
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT1  = 2'd1,
    GNT2  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;
`endif

  state_t r_state;
  // 0 = master 1 was granted most recently, 1 = master 2
  logic   r_last;

`ifdef WB_ARB_TIMEOUT_EN
  logic [CW-1:0] r_cnt;
  logic          r_tout;
  logic          w_stbGranted;

  assign w_stbGranted = (r_state == GNT1) ? stb_o1 :
                        (r_state == GNT2) ? stb_o2 : 1'b0;

  // Arbitration FSM with watchdog. The counter tracks consecutive strobe
  // cycles without an ack; hitting TIMEOUT moves to ABORT and fires tout.
  // A master dropping cyc takes priority over a simultaneous timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_tout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (cyc_o1 && (!cyc_o2 || r_last)) begin
            r_state <= GNT1;
            r_last  <= 1'b0;
          end else if (cyc_o2) begin
            r_state <= GNT2;
            r_last  <= 1'b1;
          end
        end
        GNT1, GNT2: begin
          if ((r_state == GNT1) ? !cyc_o1 : !cyc_o2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!w_stbGranted || ack_i) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state <= ABORT;
            r_cnt   <= '0;
            r_tout  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ABORT: begin
          r_cnt <= '0;
          // r_last still names the aborted master
          if (r_last ? !cyc_o2 : !cyc_o1) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign tout_o = r_tout;
`else
  // Arbitration FSM. Ties go to the master that was not granted last; an
  // owner keeps the bus until it drops cyc, then the FSM passes via IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (cyc_o1 && (!cyc_o2 || r_last)) begin
            r_state <= GNT1;
            r_last  <= 1'b0;
          end else if (cyc_o2) begin
            r_state <= GNT2;
            r_last  <= 1'b1;
          end
        end
        GNT1: begin
          if (!cyc_o1) r_state <= IDLE;
        end
        GNT2: begin
          if (!cyc_o2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // TIMEOUT only matters for the watchdog build
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);

  assign tout_o = 1'b0;
`endif

  // Slave-side mux driven by the registered state, so the owner's changes
  // pass straight through within a grant while everyone else is blocked.
  always_comb begin
    dat_o = '0;
    adr_o = '0;
    we_o  = 1'b0;
    stb_o = 1'b0;
    cyc_o = 1'b0;
    if (r_state == GNT1) begin
      dat_o = dat_o1;
      adr_o = adr_o1;
      we_o  = we_o1;
      stb_o = stb_o1;
      cyc_o = cyc_o1;
    end else if (r_state == GNT2) begin
      dat_o = dat_o2;
      adr_o = adr_o2;
      we_o  = we_o2;
      stb_o = stb_o2;
      cyc_o = cyc_o2;
    end
  end

  assign ack_i1 = ack_i & (r_state == GNT1);
  assign ack_i2 = ack_i & (r_state == GNT2);
  assign gnt_o  = (r_state == GNT1) ? 2'b01 :
                  (r_state == GNT2) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_rr_arbiter
//
// Directed bench for wishbone_rr_arbiter. Each step drives both masters and
// the slave ack one cycle at a time, queues the outputs that step should
// produce, and compares them against the DUT a few time units later.
// ---------------------------------------------------------------------------
module tb_wishbone_rr_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic [DW-1:0] wbDat;
  logic [AW-1:0] wbAdr;
  logic          wbWe, wbStb, wbCyc, wbAck;
  logic [DW-1:0] m1Dat, m2Dat;
  logic [AW-1:0] m1Adr, m2Adr;
  logic          m1We, m1Stb, m1Cyc, m1Ack;
  logic          m2We, m2Stb, m2Cyc, m2Ack;
  logic [1:0]    gnt;
  logic          tout;

  typedef struct {
    string       tag;
    logic [1:0]  gnt;
    logic [26:0] bus;
    logic [1:0]  acks;
    logic        tout;
  } exp_t;

  exp_t sbQueue[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(15)) dut (
    .clk_i   (clk),
    .rst_n_i (rstN),
    .dat_o   (wbDat),
    .adr_o   (wbAdr),
    .we_o    (wbWe),
    .stb_o   (wbStb),
    .cyc_o   (wbCyc),
    .ack_i   (wbAck),
    .dat_o1  (m1Dat),
    .adr_o1  (m1Adr),
    .we_o1   (m1We),
    .stb_o1  (m1Stb),
    .cyc_o1  (m1Cyc),
    .ack_i1  (m1Ack),
    .dat_o2  (m2Dat),
    .adr_o2  (m2Adr),
    .we_o2   (m2We),
    .stb_o2  (m2Stb),
    .cyc_o2  (m2Cyc),
    .ack_i2  (m2Ack),
    .gnt_o   (gnt),
    .tout_o  (tout)
  );

  // Packs {cyc, stb, we, adr, dat} as seen on the slave side
  function automatic logic [26:0] busVal(input logic c, input logic s, input logic w,
                                         input logic [15:0] a, input logic [7:0] d);
    return {c, s, w, a, d};
  endfunction

  task automatic applyStimulus(input logic c1, input logic s1, input logic w1,
                               input logic [15:0] a1, input logic [7:0] d1,
                               input logic c2, input logic s2, input logic w2,
                               input logic [15:0] a2, input logic [7:0] d2,
                               input logic ack);
    m1Cyc = c1; m1Stb = s1; m1We = w1; m1Adr = a1; m1Dat = d1;
    m2Cyc = c2; m2Stb = s2; m2We = w2; m2Adr = a2; m2Dat = d2;
    wbAck = ack;
  endtask

  task automatic expectOut(input string tag, input logic [1:0] g, input logic [26:0] b,
                           input logic [1:0] a, input logic t);
    exp_t e;
    e.tag = tag; e.gnt = g; e.bus = b; e.acks = a; e.tout = t;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [26:0] obsBus;
    if (sbQueue.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e      = sbQueue.pop_front();
      obsBus = {wbCyc, wbStb, wbWe, wbAdr, wbDat};
      testsRun++;
      assert (gnt === e.gnt) else begin
        testsFailed++;
        $error("[TB] FAIL %s gnt: observed %b expected %b", e.tag, gnt, e.gnt);
      end
      testsRun++;
      assert (obsBus === e.bus) else begin
        testsFailed++;
        $error("[TB] FAIL %s bus: observed %h expected %h", e.tag, obsBus, e.bus);
      end
      testsRun++;
      assert ({m1Ack, m2Ack} === e.acks) else begin
        testsFailed++;
        $error("[TB] FAIL %s acks: observed %b expected %b", e.tag, {m1Ack, m2Ack}, e.acks);
      end
      testsRun++;
      assert (tout === e.tout) else begin
        testsFailed++;
        $error("[TB] FAIL %s tout: observed %b expected %b", e.tag, tout, e.tout);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Global bound so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: observed no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [26:0] busM1, busM2, busT1, busT2, busW;
    busM1 = busVal(1'b1, 1'b1, 1'b1, 16'h1234, 8'hA5);
    busM2 = busVal(1'b1, 1'b1, 1'b0, 16'h5555, 8'h5A);
    busT1 = busVal(1'b1, 1'b1, 1'b1, 16'h1111, 8'h11);
    busT2 = busVal(1'b1, 1'b1, 1'b0, 16'h2222, 8'h22);
    busW  = busVal(1'b1, 1'b1, 1'b0, 16'hBEEF, 8'h3C);

    // Reset held with both masters requesting: everything stays quiet
    rstN = 1'b0;
    applyStimulus(1, 1, 1, 16'h1234, 8'hA5, 1, 1, 0, 16'h5555, 8'h5A, 1);
    expectOut("reset0", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("reset1", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("release", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();

    // Single master 1 request with one-cycle grant latency
    nextCycle();
    applyStimulus(1, 1, 1, 16'h1234, 8'hA5, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("latency", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("single_gnt", 2'b01, busM1, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(1, 1, 1, 16'h1234, 8'hA5, 0, 0, 0, 16'h0, 8'h0, 1);
    expectOut("single_ack", 2'b01, busM1, 2'b10, 1'b0); #3; checkOutput();

    // Master 2 contends while master 1 keeps cyc for 6 cycles
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      applyStimulus(1, 1, 1, 16'h1234, 8'hA5, 1, 1, 0, 16'h5555, 8'h5A, (i == 2));
      expectOut($sformatf("hold%0d", i), 2'b01, busM1, (i == 2) ? 2'b10 : 2'b00, 1'b0);
      #3; checkOutput();
    end

    // Master 1 releases: one idle cycle, then master 2
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h5555, 8'h5A, 0);
    expectOut("m1_drop", 2'b01, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("gap", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("m2_gnt", 2'b10, busM2, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h5555, 8'h5A, 1);
    expectOut("m2_ack", 2'b10, busM2, 2'b01, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("m2_drop", 2'b10, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("idle", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();

    // Tie after master 2 was last: master 1 wins, then master 2, then master 1
    nextCycle();
    applyStimulus(1, 1, 1, 16'h1111, 8'h11, 1, 1, 0, 16'h2222, 8'h22, 0);
    expectOut("tie_req", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("tie_m1", 2'b01, busT1, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 1, 1, 0, 16'h2222, 8'h22, 0);
    expectOut("tie_m1_drop", 2'b01, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("tie_gap", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("tie_m2", 2'b10, busT2, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("tie_m2_drop", 2'b10, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(1, 1, 1, 16'h1111, 8'h11, 1, 1, 0, 16'h2222, 8'h22, 0);
    expectOut("tie2_req", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("tie2_m1", 2'b01, busT1, 2'b00, 1'b0); #3; checkOutput();

    // Reset mid-grant: outputs clear at once; afterwards a tie goes to master 1
    nextCycle();
    applyStimulus(1, 1, 1, 16'h1111, 8'h11, 1, 1, 0, 16'h2222, 8'h22, 1);
    expectOut("pre_reset", 2'b01, busT1, 2'b10, 1'b0); #2; checkOutput();
    rstN = 1'b0;
    #1;
    expectOut("async_reset", 2'b00, 27'd0, 2'b00, 1'b0); checkOutput();
    nextCycle();
    applyStimulus(1, 1, 1, 16'h1111, 8'h11, 1, 1, 0, 16'h2222, 8'h22, 0);
    expectOut("in_reset", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    rstN = 1'b1;
    expectOut("post_reset", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("reset_tie_m1", 2'b01, busT1, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("reset_tie_drop", 2'b01, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("idle2", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();

    // Master 1 strobes against a slave that never acks
    nextCycle();
    applyStimulus(1, 1, 0, 16'hBEEF, 8'h3C, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("hang_req", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      nextCycle();
      expectOut($sformatf("hang%0d", i), 2'b01, busW, 2'b00, 1'b0); #3; checkOutput();
    end
    nextCycle();
    expectOut("abort_pulse", 2'b00, 27'd0, 2'b00, 1'b1); #3; checkOutput();
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      expectOut($sformatf("abort_hold%0d", i), 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    end
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("abort_drop", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    applyStimulus(1, 1, 0, 16'hBEEF, 8'h3C, 0, 0, 0, 16'h0, 8'h0, 0);
    expectOut("abort_idle", 2'b00, 27'd0, 2'b00, 1'b0); #3; checkOutput();
    nextCycle();
    expectOut("abort_regnt", 2'b01, busW, 2'b00, 1'b0); #3; checkOutput();
`else
    for (int i = 0; i < 110; i++) begin
      nextCycle();
      expectOut($sformatf("hang%0d", i), 2'b01, busW, 2'b00, 1'b0); #3; checkOutput();
    end
`endif
    nextCycle();
    applyStimulus(0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0);
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
